// File: rtl/led_status_driver.sv
// Status LED blink-code generator (N blinks for one-hot mode N, then a dark gap)
// plus a pulse stretcher that makes short comm_active bursts visible on a second LED.
module led_status_driver #(
  parameter int MODE_WIDTH       = 4,
  parameter int SYS_FREQ_HZ      = 12_000_000,
  parameter int BLINK_ON_MS      = 200,
  parameter int BLINK_OFF_MS     = 200,
  parameter int GAP_MS           = 1_000,
  parameter int ACTIVITY_HOLD_MS = 50,
  parameter bit LEDS_ACTIVE_LOW  = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [MODE_WIDTH-1:0] mode_select,
  input  logic                  comm_active,
  output logic                  status_led,
  output logic                  activity_led
);

  localparam int TICKS_PER_MS = SYS_FREQ_HZ / 1_000;
  localparam int ON_COUNT     = BLINK_ON_MS * TICKS_PER_MS;
  localparam int OFF_COUNT    = BLINK_OFF_MS * TICKS_PER_MS;
  localparam int GAP_COUNT    = GAP_MS * TICKS_PER_MS;
  localparam int HOLD_COUNT   = ACTIVITY_HOLD_MS * TICKS_PER_MS;
  localparam int MAX_ONOFF    = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
  localparam int MAX_COUNT    = (MAX_ONOFF > GAP_COUNT) ? MAX_ONOFF : GAP_COUNT;
  localparam int TW           = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int HW           = $clog2(HOLD_COUNT + 1);
  localparam int NW           = $clog2(MODE_WIDTH + 1);

  if (ON_COUNT < 1 || OFF_COUNT < 1 || GAP_COUNT < 1 || HOLD_COUNT < 1) begin : g_bad_counts
    $error("led_status_driver: every derived count must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_GAP,
    ST_ON,
    ST_OFF,
    ST_SOLID
  } state_t;

  state_t                  state, state_n;
  logic [TW-1:0]           timer, timer_n;
  logic [NW-1:0]           blink_cnt, blink_cnt_n;
  logic [MODE_WIDTH-1:0]   mode_q;
  logic [NW-1:0]           ones, mode_n;
  logic                    mode_valid;
  logic                    mode_changed;
  logic                    status_on;
  logic [HW-1:0]           hold, hold_n;

  always_comb begin
    ones   = '0;
    mode_n = '0;
    for (int unsigned i = 0; i < MODE_WIDTH; i++) begin
      if (mode_select[i]) begin
        ones   = ones + NW'(1);
        mode_n = NW'(i + 1);
      end
    end
    mode_valid   = (ones == NW'(1));
    mode_changed = (mode_select != mode_q);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_GAP;
      timer      <= '0;
      blink_cnt  <= '0;
      mode_q     <= '0;
      status_led <= LEDS_ACTIVE_LOW;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      blink_cnt  <= blink_cnt_n;
      mode_q     <= mode_select;
      status_led <= status_on ^ LEDS_ACTIVE_LOW;
    end
  end

  // A mode change overrides whatever the sequencer was doing, so every new code starts with a full gap.
  always_comb begin
    state_n     = state;
    timer_n     = timer + TW'(1);
    blink_cnt_n = blink_cnt;
    if (mode_changed) begin
      state_n     = mode_valid ? ST_GAP : ST_SOLID;
      timer_n     = '0;
      blink_cnt_n = '0;
    end else begin
      case (state)
        ST_GAP: begin
          if (timer == TW'(GAP_COUNT - 1)) begin
            state_n     = ST_ON;
            timer_n     = '0;
            blink_cnt_n = NW'(1);
          end
        end
        ST_ON: begin
          if (timer == TW'(ON_COUNT - 1)) begin
            state_n = ST_OFF;
            timer_n = '0;
          end
        end
        ST_OFF: begin
          if (timer == TW'(OFF_COUNT - 1)) begin
            timer_n = '0;
            if (blink_cnt == mode_n) begin
              state_n     = ST_GAP;
              blink_cnt_n = '0;
            end else begin
              state_n     = ST_ON;
              blink_cnt_n = blink_cnt + NW'(1);
            end
          end
        end
        default: timer_n = '0;
      endcase
    end
  end

  // LED level is decoded from the next state so the registered output lines up with the state.
  always_comb begin
    status_on = (state_n == ST_ON) || (state_n == ST_SOLID);
  end

  always_comb begin
    if (comm_active)
      hold_n = HW'(HOLD_COUNT);
    else if (hold != '0)
      hold_n = hold - HW'(1);
    else
      hold_n = '0;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hold         <= '0;
      activity_led <= LEDS_ACTIVE_LOW;
    end else begin
      hold         <= hold_n;
      activity_led <= (hold_n != '0) ^ LEDS_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Directed bench for led_status_driver: an active-high and an active-low instance
// share all inputs; expected LED levels are hand-derived cycle numbers.
module tb_led_status_driver;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mode_select = 4'b0100;
  logic       comm_active = 1'b0;
  logic       h_status, h_act, l_status, l_act;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int   cyc;
    logic comm;
    logic status;
    logic act;
  } vec_t;

  led_status_driver #(
    .MODE_WIDTH(4), .SYS_FREQ_HZ(1_000), .BLINK_ON_MS(3), .BLINK_OFF_MS(2),
    .GAP_MS(10), .ACTIVITY_HOLD_MS(4), .LEDS_ACTIVE_LOW(1'b0)
  ) dut_h (
    .sys_clk(sys_clk), .rst(rst), .mode_select(mode_select),
    .comm_active(comm_active), .status_led(h_status), .activity_led(h_act)
  );

  led_status_driver #(
    .MODE_WIDTH(4), .SYS_FREQ_HZ(1_000), .BLINK_ON_MS(3), .BLINK_OFF_MS(2),
    .GAP_MS(10), .ACTIVITY_HOLD_MS(4), .LEDS_ACTIVE_LOW(1'b1)
  ) dut_l (
    .sys_clk(sys_clk), .rst(rst), .mode_select(mode_select),
    .comm_active(comm_active), .status_led(l_status), .activity_led(l_act)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {h_status,h_act,l_status,l_act} = %b, required %b", name, got, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int c, input logic s, input logic a);
    while (cyc < c) step();
    check($sformatf("%s@cycle%0d", tag, c), {h_status, h_act, l_status, l_act}, {s, a, ~s, ~a});
  endtask

  // Leaves the bench #1 after an edge with rst released; the next edge is cycle 1.
  task automatic do_reset();
    rst = 1'b1;
    comm_active = 1'b0;
    #2;
    step();
    step();
    check("reset_state", {h_status, h_act, l_status, l_act}, 4'b0011);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    vec_t s1 [22];
    s1 = '{
      '{ 1, 1'b0, 1'b0, 1'b0}, '{ 5, 1'b1, 1'b0, 1'b0}, '{ 6, 1'b0, 1'b0, 1'b1},
      '{ 9, 1'b0, 1'b0, 1'b1}, '{10, 1'b0, 1'b0, 1'b0}, '{11, 1'b0, 1'b1, 1'b0},
      '{13, 1'b0, 1'b1, 1'b0}, '{14, 1'b0, 1'b0, 1'b0}, '{15, 1'b0, 1'b0, 1'b0},
      '{16, 1'b0, 1'b1, 1'b0}, '{18, 1'b0, 1'b1, 1'b0}, '{19, 1'b0, 1'b0, 1'b0},
      '{20, 1'b0, 1'b0, 1'b0}, '{21, 1'b0, 1'b1, 1'b0}, '{23, 1'b0, 1'b1, 1'b0},
      '{24, 1'b0, 1'b0, 1'b0}, '{25, 1'b0, 1'b0, 1'b0}, '{26, 1'b0, 1'b0, 1'b0},
      '{35, 1'b0, 1'b0, 1'b0}, '{36, 1'b1 & 1'b0, 1'b1, 1'b0}, '{38, 1'b0, 1'b1, 1'b0},
      '{39, 1'b0, 1'b0, 1'b0}
    };

    // Mode 3 blink code (period 25) with a single-cycle activity pulse during cycle 5.
    mode_select = 4'b0100;
    do_reset();
    foreach (s1[i]) begin
      expect_at("mode3", s1[i].cyc, s1[i].status, s1[i].act);
      comm_active = s1[i].comm;
    end

    // Switch mode 3 -> mode 1 during cycle 20: restart with a full gap, period 15.
    do_reset();
    expect_at("m3to1", 19, 1'b0, 1'b0);
    expect_at("m3to1", 20, 1'b0, 1'b0);
    mode_select = 4'b0001;
    expect_at("m3to1", 21, 1'b0, 1'b0);
    expect_at("m3to1", 30, 1'b0, 1'b0);
    expect_at("m3to1", 31, 1'b1, 1'b0);
    expect_at("m3to1", 33, 1'b1, 1'b0);
    expect_at("m3to1", 34, 1'b0, 1'b0);
    expect_at("m3to1", 35, 1'b0, 1'b0);
    expect_at("m3to1", 36, 1'b0, 1'b0);
    expect_at("m3to1", 45, 1'b0, 1'b0);
    expect_at("m3to1", 46, 1'b1, 1'b0);
    expect_at("m3to1", 48, 1'b1, 1'b0);
    expect_at("m3to1", 49, 1'b0, 1'b0);

    // Invalid inputs give solid on; a valid mode 4 restarts from a gap.
    mode_select = 4'b0110;
    expect_at("solid", 50, 1'b1, 1'b0);
    expect_at("solid", 60, 1'b1, 1'b0);
    mode_select = 4'b0000;
    expect_at("solid", 61, 1'b1, 1'b0);
    expect_at("solid", 62, 1'b1, 1'b0);
    mode_select = 4'b1000;
    expect_at("mode4", 63, 1'b0, 1'b0);
    expect_at("mode4", 72, 1'b0, 1'b0);
    expect_at("mode4", 73, 1'b1, 1'b0);
    expect_at("mode4", 75, 1'b1, 1'b0);
    expect_at("mode4", 76, 1'b0, 1'b0);
    expect_at("mode4", 78, 1'b1, 1'b0);
    expect_at("mode4", 83, 1'b1, 1'b0);
    expect_at("mode4", 88, 1'b1, 1'b0);
    expect_at("mode4", 90, 1'b1, 1'b0);
    expect_at("mode4", 91, 1'b0, 1'b0);
    expect_at("mode4", 92, 1'b0, 1'b0);
    expect_at("mode4", 102, 1'b0, 1'b0);
    expect_at("mode4", 103, 1'b1, 1'b0);

    // Activity retrigger (pulses during 5 and 8) and a 3-cycle burst, under mode 1.
    mode_select = 4'b0001;
    do_reset();
    expect_at("act", 5, 1'b0, 1'b0);
    comm_active = 1'b1;
    expect_at("act", 6, 1'b0, 1'b1);
    comm_active = 1'b0;
    expect_at("act", 8, 1'b0, 1'b1);
    comm_active = 1'b1;
    expect_at("act", 9, 1'b0, 1'b1);
    comm_active = 1'b0;
    expect_at("act", 10, 1'b0, 1'b1);
    expect_at("act", 12, 1'b1, 1'b1);
    expect_at("act", 13, 1'b1, 1'b0);
    expect_at("act", 20, 1'b0, 1'b0);
    comm_active = 1'b1;
    expect_at("act", 21, 1'b0, 1'b1);
    expect_at("act", 22, 1'b0, 1'b1);
    expect_at("act", 23, 1'b0, 1'b1);
    comm_active = 1'b0;
    expect_at("act", 25, 1'b0, 1'b1);
    expect_at("act", 26, 1'b1, 1'b1);
    comm_active = 1'b1;
    expect_at("act", 27, 1'b1, 1'b1);
    comm_active = 1'b0;

    // Asynchronous reset while ON and activity active: outputs drop without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {h_status, h_act, l_status, l_act}, 4'b0011);
    step();
    step();
    check("reset_held", {h_status, h_act, l_status, l_act}, 4'b0011);
    rst = 1'b0;
    cyc = 0;
    expect_at("post_rst", 1, 1'b0, 1'b0);
    expect_at("post_rst", 10, 1'b0, 1'b0);
    expect_at("post_rst", 11, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
